// File: rtl/prover_line_points.sv
// rtl/prover_line_points.sv - line-point generator gamma(t) = w1 + t*(w2-w1) over F_Q
//
// Collects w1 then w2 (nCoords coins each) from the tau stream. It forms
// w2-w1 in place over w2, then walks gamma(t) for t = 0..nPoints-1. One
// shared modular add/sub datapath handles one coordinate per cycle.
//
// Ports:
//   clk, rstb          clock, asynchronous active-low reset
//   i_restart          synchronous abort/clear, highest priority
//   i_tau_valid/o_tau_ready, i_tau          coin input stream
//   o_w1, o_w2_m_w1    captured w1 and (w2-w1) mod Q
//   o_pt_valid/i_pt_ready, o_pt_t, o_pt_val, o_pt_om   point output stream
//   o_busy             high while differencing or emitting
//   o_done_pulse       one cycle after the last point is accepted
module prover_line_points #(
   parameter int unsigned nBits        = 61,
   parameter logic [63:0] Q            = 64'h1FFF_FFFF_FFFF_FFFF,
   parameter int unsigned nCoords      = 3,
   parameter int unsigned nPoints      = 4,
   parameter bit          emitOneMinus = 1'b1,
   parameter int unsigned nTBits       = $clog2(nPoints)
) (
   input  logic                            clk,
   input  logic                            rstb,
   input  logic                            i_restart,
   input  logic                            i_tau_valid,
   output logic                            o_tau_ready,
   input  logic [nBits-1:0]                i_tau,
   output logic [nCoords-1:0][nBits-1:0]   o_w1,
   output logic [nCoords-1:0][nBits-1:0]   o_w2_m_w1,
   output logic                            o_pt_valid,
   input  logic                            i_pt_ready,
   output logic [nTBits-1:0]               o_pt_t,
   output logic [nCoords-1:0][nBits-1:0]   o_pt_val,
   output logic [nCoords-1:0][nBits-1:0]   o_pt_om,
   output logic                            o_busy,
   output logic                            o_done_pulse
);

   generate
      if (Q <= 64'd2 || (nBits < 64 && (Q >> nBits) != 64'd0)) begin : g_bad_q
         $error("prover_line_points: Q must satisfy 2 < Q < 2^nBits");
      end
      if (nCoords < 1) begin : g_bad_coords
         $error("prover_line_points: nCoords must be >= 1");
      end
      if (nPoints < 2) begin : g_bad_points
         $error("prover_line_points: nPoints must be >= 2");
      end
      if (nTBits != $clog2(nPoints)) begin : g_bad_tbits
         $error("prover_line_points: nTBits must not be overridden");
      end
   endgenerate

   localparam int unsigned       KW     = (nCoords > 1) ? $clog2(nCoords) : 1;
   localparam logic [KW-1:0]     K_LAST = KW'(nCoords - 1);
   localparam logic [nTBits-1:0] T_LAST = nTBits'(nPoints - 1);
   localparam logic [nBits-1:0]  QN     = Q[nBits-1:0];
   localparam logic [nBits:0]    QX     = {1'b0, QN};
   localparam logic [nBits-1:0]  ONE    = nBits'(1);

   typedef enum logic [2:0] {
      S_COLLECT_W1,
      S_COLLECT_W2,
      S_DIFF,
      S_EMIT,
      S_STEP,
      S_DONE
   } state_t;

   state_t                        r_state;
   state_t                        w_next;
   logic [KW-1:0]                 r_k;
   logic [nCoords-1:0][nBits-1:0] r_w1;
   logic [nCoords-1:0][nBits-1:0] r_dm;      // raw w2 until DIFF rewrites it
   logic [nCoords-1:0][nBits-1:0] r_pt_val;
   logic [nTBits-1:0]             r_pt_t;
   logic                          r_done;

   logic                          w_k_last;
   logic                          w_pt_hs;
   logic                          w_sub;
   logic [nBits-1:0]              w_a;
   logic [nBits-1:0]              w_b;
   logic [nBits:0]                w_raw;
   logic [nBits:0]                w_fix;
   logic                          w_use_fix;
   logic [nBits-1:0]              w_alu;

   assign w_k_last = (r_k == K_LAST);

   // Shared modular datapath. DIFF computes dm[k]-w1[k]; STEP computes
   // pt_val[k]+dm[k]. One spare bit catches the borrow or the carry past Q.
   assign w_sub     = (r_state == S_DIFF);
   assign w_a       = w_sub ? r_dm[r_k] : r_pt_val[r_k];
   assign w_b       = w_sub ? r_w1[r_k] : r_dm[r_k];
   assign w_raw     = {1'b0, w_a} + (w_sub ? ~{1'b0, w_b} : {1'b0, w_b})
                      + {{nBits{1'b0}}, w_sub};
   assign w_fix     = w_sub ? (w_raw + QX) : (w_raw - QX);
   assign w_use_fix = w_sub ? w_raw[nBits] : (w_raw >= QX);
   assign w_alu     = w_use_fix ? w_fix[nBits-1:0] : w_raw[nBits-1:0];

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state <= S_COLLECT_W1;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      o_tau_ready = 1'b0;
      o_pt_valid  = 1'b0;
      o_busy      = 1'b0;
      case (r_state)
         S_COLLECT_W1: begin
            o_tau_ready = 1'b1;
            if (i_tau_valid && w_k_last) w_next = S_COLLECT_W2;
         end
         S_COLLECT_W2: begin
            o_tau_ready = 1'b1;
            if (i_tau_valid && w_k_last) w_next = S_DIFF;
         end
         S_DIFF: begin
            o_busy = 1'b1;
            if (w_k_last) w_next = S_EMIT;
         end
         S_EMIT: begin
            o_busy     = 1'b1;
            o_pt_valid = 1'b1;
            if (i_pt_ready) w_next = (r_pt_t == T_LAST) ? S_DONE : S_STEP;
         end
         S_STEP: begin
            o_busy = 1'b1;
            if (w_k_last) w_next = S_EMIT;
         end
         S_DONE: begin
            w_next = S_DONE;
         end
         default: begin
            w_next = S_COLLECT_W1;
         end
      endcase
      if (i_restart) w_next = S_COLLECT_W1;
   end

   assign w_pt_hs = o_pt_valid & i_pt_ready;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_k      <= '0;
         r_w1     <= '0;
         r_dm     <= '0;
         r_pt_val <= '0;
         r_pt_t   <= '0;
         r_done   <= 1'b0;
      end else if (i_restart) begin
         r_k      <= '0;
         r_w1     <= '0;
         r_dm     <= '0;
         r_pt_val <= '0;
         r_pt_t   <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_COLLECT_W1: begin
               if (i_tau_valid) begin
                  r_w1[r_k]     <= i_tau;
                  r_pt_val[r_k] <= i_tau;   // gamma(0) = w1
                  r_k           <= w_k_last ? '0 : r_k + KW'(1);
               end
            end
            S_COLLECT_W2: begin
               if (i_tau_valid) begin
                  r_dm[r_k] <= i_tau;
                  r_k       <= w_k_last ? '0 : r_k + KW'(1);
               end
            end
            S_DIFF: begin
               r_dm[r_k] <= w_alu;
               r_k       <= w_k_last ? '0 : r_k + KW'(1);
            end
            S_EMIT: begin
               if (w_pt_hs && r_pt_t == T_LAST) r_done <= 1'b1;
            end
            S_STEP: begin
               r_pt_val[r_k] <= w_alu;
               if (w_k_last) begin
                  r_k <= '0;
                  if (r_pt_t != T_LAST) r_pt_t <= r_pt_t + nTBits'(1);
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // (1 - x) mod Q: x = 0 -> 1, x = 1 -> 0, otherwise Q + 1 - x.
   genvar g;
   generate
      for (g = 0; g < nCoords; g++) begin : g_om
         if (emitOneMinus) begin : g_on
            assign o_pt_om[g] = (r_pt_val[g] <= ONE) ? (ONE - r_pt_val[g])
                                                     : (QN - r_pt_val[g] + ONE);
         end else begin : g_off
            assign o_pt_om[g] = '0;
         end
      end
   endgenerate

   assign o_w1         = r_w1;
   assign o_w2_m_w1    = r_dm;
   assign o_pt_val     = r_pt_val;
   assign o_pt_t       = r_pt_t;
   assign o_done_pulse = r_done;

endmodule

// File: tb/tb_prover_line_points.sv
// tb/tb_prover_line_points.sv - directed bench for prover_line_points
module tb_prover_line_points;

   typedef logic [2:0][6:0] vec3_t;

   logic clk  = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;
   int c_last = 0;
   int a_done_cnt = 0;
   vec3_t exp_pt [4];

   // DUT A: Q=97, 3 coords, 4 points
   logic        a_restart = 1'b0, a_tau_valid = 1'b0, a_pt_ready = 1'b0;
   logic [6:0]  a_tau = '0;
   logic        a_tau_ready, a_pt_valid, a_busy, a_done;
   logic [1:0]  a_pt_t;
   vec3_t       a_w1, a_dm, a_pt_val, a_pt_om;

   // DUT B: Q=97, 1 coord, 2 points
   logic        b_restart = 1'b0, b_tau_valid = 1'b0, b_pt_ready = 1'b0;
   logic [6:0]  b_tau = '0;
   logic        b_tau_ready, b_pt_valid, b_busy, b_done;
   logic [0:0]  b_pt_t;
   logic [0:0][6:0] b_w1, b_dm, b_pt_val, b_pt_om;

   prover_line_points #(.nBits(7), .Q(64'd97), .nCoords(3), .nPoints(4), .emitOneMinus(1'b1)) u_a (
      .clk(clk), .rstb(rstb), .i_restart(a_restart), .i_tau_valid(a_tau_valid),
      .o_tau_ready(a_tau_ready), .i_tau(a_tau), .o_w1(a_w1), .o_w2_m_w1(a_dm),
      .o_pt_valid(a_pt_valid), .i_pt_ready(a_pt_ready), .o_pt_t(a_pt_t),
      .o_pt_val(a_pt_val), .o_pt_om(a_pt_om), .o_busy(a_busy), .o_done_pulse(a_done)
   );

   prover_line_points #(.nBits(7), .Q(64'd97), .nCoords(1), .nPoints(2), .emitOneMinus(1'b1)) u_b (
      .clk(clk), .rstb(rstb), .i_restart(b_restart), .i_tau_valid(b_tau_valid),
      .o_tau_ready(b_tau_ready), .i_tau(b_tau), .o_w1(b_w1), .o_w2_m_w1(b_dm),
      .o_pt_valid(b_pt_valid), .i_pt_ready(b_pt_ready), .o_pt_t(b_pt_t),
      .o_pt_val(b_pt_val), .o_pt_om(b_pt_om), .o_busy(b_busy), .o_done_pulse(b_done)
   );

   always @(negedge clk) if (a_done) a_done_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic vec3_t mk3(input int a0, input int a1, input int a2);
      vec3_t v;
      v[0] = 7'(a0);
      v[1] = 7'(a1);
      v[2] = 7'(a2);
      return v;
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send_a(input logic [6:0] v);
      a_tau_valid = 1'b1;
      a_tau       = v;
      c_last      = cyc;
      step();
      a_tau_valid = 1'b0;
   endtask

   task automatic load_a(input vec3_t w1v, input vec3_t w2v);
      for (int k = 0; k < 3; k++) send_a(w1v[k]);
      for (int k = 0; k < 3; k++) send_a(w2v[k]);
   endtask

   task automatic wait_a_valid(output bit ok);
      int n = 0;
      while (!a_pt_valid && n < 40) begin
         step();
         n++;
      end
      ok = a_pt_valid;
   endtask

   task automatic test_reset();
      rstb = 1'b0;
      step();
      step();
      n_total++;
      if (a_tau_ready !== 1'b1 || a_pt_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0)
         $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b done=%b want 1 0 0 0",
                  a_tau_ready, a_pt_valid, a_busy, a_done);
      else n_pass++;
      n_total++;
      if (a_w1 !== '0 || a_dm !== '0 || a_pt_val !== '0 || a_pt_t !== 2'd0)
         $display("FAIL reset_data: w1=%h dm=%h pt=%h t=%0d want all 0", a_w1, a_dm, a_pt_val, a_pt_t);
      else n_pass++;
      rstb = 1'b1;
      step();
   endtask

   task automatic test_basic();
      bit ok;
      int h = 0;
      a_pt_ready = 1'b1;
      load_a(mk3(5, 10, 96), mk3(7, 3, 0));
      n_total++;
      if (a_busy !== 1'b1 || a_tau_ready !== 1'b0)
         $display("FAIL diff_busy: busy=%b ready=%b want 1 0", a_busy, a_tau_ready);
      else n_pass++;
      wait_a_valid(ok);
      n_total++;
      if (!ok || cyc != c_last + 4)
         $display("FAIL first_latency: valid=%b cyc=%0d want cyc %0d", ok, cyc, c_last + 4);
      else n_pass++;
      n_total++;
      if (a_dm !== mk3(2, 90, 1) || a_w1 !== mk3(5, 10, 96))
         $display("FAIL diff_value: dm=%h w1=%h want %h %h", a_dm, a_w1, mk3(2, 90, 1), mk3(5, 10, 96));
      else n_pass++;
      n_total++;
      if (a_pt_om !== mk3(93, 88, 2))
         $display("FAIL om_t0: got %h want %h", a_pt_om, mk3(93, 88, 2));
      else n_pass++;
      for (int t = 0; t < 4; t++) begin
         if (t > 0) begin
            wait_a_valid(ok);
            n_total++;
            if (!ok || cyc != h + 4)
               $display("FAIL step_latency t%0d: valid=%b cyc=%0d want %0d", t, ok, cyc, h + 4);
            else n_pass++;
         end
         n_total++;
         if (a_pt_t !== 2'(t) || a_pt_val !== exp_pt[t])
            $display("FAIL point t%0d: t=%0d val=%h want %0d %h", t, a_pt_t, a_pt_val, t, exp_pt[t]);
         else n_pass++;
         h = cyc;
         step();
      end
      n_total++;
      if (a_done !== 1'b1 || a_done_cnt != 1)
         $display("FAIL done_pulse: done=%b count=%0d want 1 1", a_done, a_done_cnt);
      else n_pass++;
      step();
      step();
      n_total++;
      if (a_done_cnt != 1 || a_pt_valid !== 1'b0 || a_tau_ready !== 1'b0 ||
          a_pt_val !== exp_pt[3] || a_pt_t !== 2'd3)
         $display("FAIL done_hold: count=%0d valid=%b ready=%b val=%h t=%0d want 1 0 0 %h 3",
                  a_done_cnt, a_pt_valid, a_tau_ready, a_pt_val, a_pt_t, exp_pt[3]);
      else n_pass++;
   endtask

   task automatic test_ignore_done();
      a_tau_valid = 1'b1;
      a_tau       = 7'd55;
      step();
      step();
      a_tau_valid = 1'b0;
      n_total++;
      if (a_w1 !== mk3(5, 10, 96) || a_dm !== mk3(2, 90, 1) || a_pt_val !== exp_pt[3] ||
          a_pt_t !== 2'd3 || a_tau_ready !== 1'b0 || a_busy !== 1'b0)
         $display("FAIL tau_in_done: w1=%h dm=%h val=%h t=%0d ready=%b busy=%b",
                  a_w1, a_dm, a_pt_val, a_pt_t, a_tau_ready, a_busy);
      else n_pass++;
      a_restart = 1'b1;
      step();
      a_restart = 1'b0;
      n_total++;
      if (a_tau_ready !== 1'b1 || a_pt_t !== 2'd0 || a_w1 !== '0 || a_pt_val !== '0)
         $display("FAIL restart_done: ready=%b t=%0d w1=%h val=%h want 1 0 0 0",
                  a_tau_ready, a_pt_t, a_w1, a_pt_val);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      bit ok;
      bit held;
      a_pt_ready = 1'b0;
      load_a(mk3(5, 10, 96), mk3(7, 3, 0));
      a_tau_valid = 1'b1;
      a_tau       = 7'd55;
      wait_a_valid(ok);
      step();
      a_tau_valid = 1'b0;
      n_total++;
      if (!ok || a_w1 !== mk3(5, 10, 96) || a_dm !== mk3(2, 90, 1) ||
          a_pt_val !== exp_pt[0] || a_pt_t !== 2'd0)
         $display("FAIL tau_in_diff_emit: valid=%b w1=%h dm=%h val=%h t=%0d",
                  ok, a_w1, a_dm, a_pt_val, a_pt_t);
      else n_pass++;
      a_pt_ready = 1'b1;
      step();
      a_pt_ready = 1'b0;
      wait_a_valid(ok);
      held = ok;
      for (int i = 0; i < 5; i++) begin
         if (a_pt_valid !== 1'b1 || a_pt_t !== 2'd1 || a_pt_val !== exp_pt[1]) held = 1'b0;
         step();
      end
      n_total++;
      if (!held || a_pt_valid !== 1'b1 || a_pt_t !== 2'd1 || a_pt_val !== exp_pt[1])
         $display("FAIL backpressure_hold: valid=%b t=%0d val=%h want 1 1 %h",
                  a_pt_valid, a_pt_t, a_pt_val, exp_pt[1]);
      else n_pass++;
      a_pt_ready = 1'b1;
      step();
      wait_a_valid(ok);
      n_total++;
      if (!ok || a_pt_t !== 2'd2 || a_pt_val !== exp_pt[2])
         $display("FAIL no_skip: valid=%b t=%0d val=%h want 1 2 %h", ok, a_pt_t, a_pt_val, exp_pt[2]);
      else n_pass++;
   endtask

   task automatic test_restart_handshake();
      bit ok;
      a_restart = 1'b1;
      step();
      a_restart = 1'b0;
      n_total++;
      if (a_tau_ready !== 1'b1 || a_pt_valid !== 1'b0 || a_pt_t !== 2'd0 ||
          a_pt_val !== '0 || a_w1 !== '0 || a_dm !== '0)
         $display("FAIL restart_hs: ready=%b valid=%b t=%0d val=%h w1=%h dm=%h",
                  a_tau_ready, a_pt_valid, a_pt_t, a_pt_val, a_w1, a_dm);
      else n_pass++;
      step();
      step();
      n_total++;
      if (a_done_cnt != 1)
         $display("FAIL restart_no_done: done count=%0d want 1", a_done_cnt);
      else n_pass++;
      a_pt_ready = 1'b0;
      load_a(mk3(0, 1, 2), mk3(1, 1, 1));
      wait_a_valid(ok);
      n_total++;
      if (!ok || a_pt_om !== mk3(1, 0, 96) || a_dm !== mk3(1, 0, 96) || a_pt_val !== mk3(0, 1, 2))
         $display("FAIL rerun_t0: valid=%b om=%h dm=%h val=%h want %h %h %h", ok, a_pt_om,
                  a_dm, a_pt_val, mk3(1, 0, 96), mk3(1, 0, 96), mk3(0, 1, 2));
      else n_pass++;
   endtask

   task automatic test_rstb_in_step();
      a_pt_ready = 1'b1;
      step();
      a_pt_ready = 1'b0;
      n_total++;
      if (a_busy !== 1'b1 || a_pt_valid !== 1'b0)
         $display("FAIL in_step: busy=%b valid=%b want 1 0", a_busy, a_pt_valid);
      else n_pass++;
      rstb = 1'b0;
      #1;
      n_total++;
      if (a_tau_ready !== 1'b1 || a_pt_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 ||
          a_w1 !== '0 || a_dm !== '0 || a_pt_val !== '0 || a_pt_t !== 2'd0)
         $display("FAIL rstb_async: ready=%b valid=%b busy=%b w1=%h dm=%h val=%h t=%0d",
                  a_tau_ready, a_pt_valid, a_busy, a_w1, a_dm, a_pt_val, a_pt_t);
      else n_pass++;
      step();
      rstb = 1'b1;
      step();
      n_total++;
      if (a_tau_ready !== 1'b1 || a_pt_val !== '0)
         $display("FAIL rstb_release: ready=%b val=%h want 1 0", a_tau_ready, a_pt_val);
      else n_pass++;
   endtask

   task automatic test_two_points();
      int n;
      int h;
      b_pt_ready  = 1'b1;
      b_tau_valid = 1'b1;
      b_tau       = 7'd96;
      step();
      b_tau  = 7'd0;
      c_last = cyc;
      step();
      b_tau_valid = 1'b0;
      n = 0;
      while (!b_pt_valid && n < 40) begin step(); n++; end
      n_total++;
      if (!b_pt_valid || cyc != c_last + 2)
         $display("FAIL b_latency: valid=%b cyc=%0d want %0d", b_pt_valid, cyc, c_last + 2);
      else n_pass++;
      n_total++;
      if (b_dm !== 7'd1 || b_pt_val !== 7'd96 || b_pt_om !== 7'd2 || b_pt_t !== 1'b0)
         $display("FAIL b_t0: dm=%0d val=%0d om=%0d t=%0d want 1 96 2 0", b_dm, b_pt_val, b_pt_om, b_pt_t);
      else n_pass++;
      h = cyc;
      step();
      n = 0;
      while (!b_pt_valid && n < 40) begin step(); n++; end
      n_total++;
      if (!b_pt_valid || cyc != h + 2 || b_pt_val !== 7'd0 || b_pt_om !== 7'd1 || b_pt_t !== 1'b1)
         $display("FAIL b_t1: valid=%b cyc=%0d val=%0d om=%0d t=%0d want 1 %0d 0 1 1",
                  b_pt_valid, cyc, b_pt_val, b_pt_om, b_pt_t, h + 2);
      else n_pass++;
      step();
      n_total++;
      if (b_done !== 1'b1 || b_pt_valid !== 1'b0)
         $display("FAIL b_done: done=%b valid=%b want 1 0", b_done, b_pt_valid);
      else n_pass++;
      step();
      n_total++;
      if (b_done !== 1'b0 || b_tau_ready !== 1'b0)
         $display("FAIL b_done_once: done=%b ready=%b want 0 0", b_done, b_tau_ready);
      else n_pass++;
   endtask

   initial begin
      exp_pt[0] = mk3(5, 10, 96);
      exp_pt[1] = mk3(7, 3, 0);
      exp_pt[2] = mk3(9, 93, 1);
      exp_pt[3] = mk3(11, 86, 2);
      test_reset();
      test_basic();
      test_ignore_done();
      test_backpressure();
      test_restart_handshake();
      test_rstb_in_step();
      test_two_points();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
